// File: rtl/game_sequencer_pkg.sv
// Shared game types and default timing constants for the game sequencer slice.
package Constants;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OVER = 2'd2
   } game_state_t;

   localparam int unsigned DEFAULT_BIRD_TICK_DIV     = 2**20;
   localparam int unsigned DEFAULT_OBSTACLE_TICK_DIV = 2**21;
   localparam int unsigned DEFAULT_HOLD_CYCLES       = 2**25;

endpackage

// File: rtl/game_sequencer_tick_divider.sv
// Free-running enable divider: one-cycle tick every DIV clocks, held at zero while clear.
module tick_divider
   import Constants::*;
#(
   parameter int unsigned DIV = DEFAULT_BIRD_TICK_DIV
) (
   input  logic clock,
   input  logic clear,
   output logic tick
);

   localparam logic [31:0] LAST = 32'(DIV - 1);

   logic [31:0] count;

   always_ff @(posedge clock) begin
      if (clear) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 32'd1;
      end
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/game_sequencer.sv
// Game-level sequencer: IDLE/RUN/OVER flow, world tick generation and high-score tracking.
module game_sequencer
   import Constants::*;
#(
   parameter int unsigned BIRD_TICK_DIV     = DEFAULT_BIRD_TICK_DIV,
   parameter int unsigned OBSTACLE_TICK_DIV = DEFAULT_OBSTACLE_TICK_DIV,
   parameter int unsigned HOLD_CYCLES       = DEFAULT_HOLD_CYCLES
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       fly,
   input  logic       collision,
   input  logic [9:0] score_in,
   output logic [1:0] state,
   output logic       world_reset,
   output logic       bird_tick,
   output logic       obstacle_tick,
   output logic       game_over,
   output logic [9:0] high_score,
   output logic       new_record
);

   localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);

   game_state_t state_q, state_d;
   logic        fly_q;
   logic        fly_hold;
   logic        run_q;
   logic [31:0] hold;
   logic [9:0]  high_q;
   logic        rec_q;
   logic        fly_rise;
   logic        hold_done;
   logic        in_run;
   logic        div_clear;
   logic        bird_raw;
   logic        obstacle_raw;

   // fly_hold masks the first post-reset cycle so a flap held through reset release is not an edge
   assign fly_rise  = fly & ~fly_q & ~fly_hold;
   assign hold_done = (hold == '0);
   assign in_run    = (state_q == RUN);
   // run_q keeps the dividers cleared through the first RUN cycle, so tick N lands DIV*N cycles in
   assign div_clear = reset | ~(in_run & run_q);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (fly_rise) state_d = RUN;
         RUN:     if (collision) state_d = OVER;
         OVER:    if (fly_rise && hold_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         fly_q    <= 1'b0;
         fly_hold <= fly;
         run_q    <= 1'b0;
         hold     <= '0;
         high_q   <= '0;
         rec_q    <= 1'b0;
      end else begin
         fly_q    <= fly;
         fly_hold <= 1'b0;
         run_q    <= in_run;
         if (in_run && collision) begin
            hold <= HOLD_LAST;
            if (score_in > high_q) begin
               high_q <= score_in;
               rec_q  <= 1'b1;
            end else begin
               rec_q  <= 1'b0;
            end
         end else if (state_q == OVER && !hold_done) begin
            hold <= hold - 32'd1;
         end
         if (state_q == OVER && state_d == IDLE) begin
            rec_q <= 1'b0;
         end
      end
   end

   tick_divider #(.DIV(BIRD_TICK_DIV)) u_bird_div (
      .clock (clock),
      .clear (div_clear),
      .tick  (bird_raw)
   );

   tick_divider #(.DIV(OBSTACLE_TICK_DIV)) u_obstacle_div (
      .clock (clock),
      .clear (div_clear),
      .tick  (obstacle_raw)
   );

   assign state         = state_q;
   assign world_reset   = (state_q == IDLE);
   assign game_over     = (state_q == OVER);
   assign bird_tick     = bird_raw & in_run & ~collision;
   assign obstacle_tick = obstacle_raw & in_run & ~collision;
   assign high_score    = high_q;
   assign new_record    = rec_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized bench for game_sequencer against a cycle-age based reference model.
module tb_game_sequencer;

   localparam int unsigned BIRD_DIV = 4;
   localparam int unsigned OBST_DIV = 8;
   localparam int unsigned HOLD     = 10;

   logic       clock = 1'b0;
   logic       reset;
   logic       fly;
   logic       collision;
   logic [9:0] score_in;
   logic [1:0] state;
   logic       world_reset;
   logic       bird_tick;
   logic       obstacle_tick;
   logic       game_over;
   logic [9:0] high_score;
   logic       new_record;

   int n_cmp = 0;
   int n_bad = 0;

   // model: 0=IDLE 1=RUN 2=OVER; ages count cycles since state entry (0 on first cycle)
   int         m_state;
   int         m_run_age;
   int         m_over_age;
   logic       m_prev;
   logic [9:0] m_high;
   logic       m_rec;

   always #5 clock = ~clock;

   game_sequencer #(
      .BIRD_TICK_DIV     (BIRD_DIV),
      .OBSTACLE_TICK_DIV (OBST_DIV),
      .HOLD_CYCLES       (HOLD)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .fly           (fly),
      .collision     (collision),
      .score_in      (score_in),
      .state         (state),
      .world_reset   (world_reset),
      .bird_tick     (bird_tick),
      .obstacle_tick (obstacle_tick),
      .game_over     (game_over),
      .high_score    (high_score),
      .new_record    (new_record)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cycle(input logic f, input logic c, input logic [9:0] s, input logic r);
      logic rise;
      logic exp_b;
      logic exp_o;
      fly       = f;
      collision = c;
      score_in  = s;
      reset     = r;
      @(negedge clock);
      exp_b = (m_state == 1) && !c && (m_run_age > 0) && (m_run_age % BIRD_DIV == 0);
      exp_o = (m_state == 1) && !c && (m_run_age > 0) && (m_run_age % OBST_DIV == 0);
      check("state", 32'(state), 32'(m_state));
      check("world_reset", 32'(world_reset), 32'(m_state == 0));
      check("game_over", 32'(game_over), 32'(m_state == 2));
      check("bird_tick", 32'(bird_tick), 32'(exp_b));
      check("obstacle_tick", 32'(obstacle_tick), 32'(exp_o));
      check("high_score", 32'(high_score), 32'(m_high));
      check("new_record", 32'(new_record), 32'(m_rec));
      @(posedge clock);
      rise = f && !m_prev;
      if (r) begin
         m_state    = 0;
         m_high     = '0;
         m_rec      = 1'b0;
         m_run_age  = 0;
         m_over_age = 0;
      end else begin
         case (m_state)
            0: if (rise) begin
               m_state   = 1;
               m_run_age = 0;
            end
            1: if (c) begin
               m_state    = 2;
               m_over_age = 0;
               if (s > m_high) begin
                  m_high = s;
                  m_rec  = 1'b1;
               end else begin
                  m_rec  = 1'b0;
               end
            end else begin
               m_run_age++;
            end
            default: if (rise && m_over_age >= int'(HOLD) - 1) begin
               m_state = 0;
               m_rec   = 1'b0;
            end else begin
               m_over_age++;
            end
         endcase
      end
      m_prev = f;
      #1;
   endtask

   initial begin
      logic       f;
      logic       c;
      logic       r;
      logic [9:0] s;
      fly        = 1'b0;
      collision  = 1'b0;
      score_in   = '0;
      reset      = 1'b1;
      m_state    = 0;
      m_run_age  = 0;
      m_over_age = 0;
      m_prev     = 1'b0;
      m_high     = '0;
      m_rec      = 1'b0;
      @(posedge clock);
      #1;

      repeat (2) cycle(1'b0, 1'b0, 10'd0, 1'b1);
      repeat (20) cycle(1'b0, 1'b0, 10'd0, 1'b0);
      check("idle_state", 32'(state), 32'd0);
      check("idle_world_reset", 32'(world_reset), 32'd1);
      check("idle_high_score", 32'(high_score), 32'd0);

      // game 1: start, collide exactly when the third bird tick is due
      cycle(1'b1, 1'b0, 10'd37, 1'b0);
      check("run_entry", 32'(state), 32'd1);
      for (int i = 0; i < 40 && m_run_age < 12; i++) cycle(1'b1, 1'b0, 10'd37, 1'b0);
      cycle(1'b1, 1'b1, 10'd37, 1'b0);
      check("over_entry", 32'(state), 32'd2);
      check("over_game_over", 32'(game_over), 32'd1);
      check("record_high", 32'(high_score), 32'd37);
      check("record_flag", 32'(new_record), 32'd1);

      for (int i = 0; i < 40 && m_over_age < 5; i++) cycle(1'b0, 1'b0, 10'd0, 1'b0);
      cycle(1'b1, 1'b0, 10'd0, 1'b0);
      check("early_flap", 32'(state), 32'd2);
      for (int i = 0; i < 40 && m_over_age < 12; i++) cycle(1'b0, 1'b0, 10'd0, 1'b0);
      cycle(1'b1, 1'b0, 10'd0, 1'b0);
      check("restart_state", 32'(state), 32'd0);
      check("restart_world_reset", 32'(world_reset), 32'd1);
      check("restart_record", 32'(new_record), 32'd0);

      // game 2: lower score keeps high score; leave OVER at the first permitted cycle
      cycle(1'b0, 1'b0, 10'd12, 1'b0);
      cycle(1'b1, 1'b0, 10'd12, 1'b0);
      repeat (5) cycle(1'b1, 1'b0, 10'd12, 1'b0);
      cycle(1'b1, 1'b1, 10'd12, 1'b0);
      check("g2_high", 32'(high_score), 32'd37);
      check("g2_record", 32'(new_record), 32'd0);
      for (int i = 0; i < 40 && m_over_age < int'(HOLD) - 1; i++) cycle(1'b0, 1'b0, 10'd0, 1'b0);
      cycle(1'b1, 1'b0, 10'd0, 1'b0);
      check("hold_boundary", 32'(state), 32'd0);

      // reset mid-RUN with fly held through release
      cycle(1'b0, 1'b0, 10'd0, 1'b0);
      cycle(1'b1, 1'b0, 10'd0, 1'b0);
      repeat (6) cycle(1'b1, 1'b0, 10'd0, 1'b0);
      cycle(1'b1, 1'b0, 10'd0, 1'b1);
      check("rst_state", 32'(state), 32'd0);
      check("rst_high", 32'(high_score), 32'd0);
      cycle(1'b1, 1'b0, 10'd0, 1'b1);
      repeat (5) cycle(1'b1, 1'b0, 10'd0, 1'b0);
      check("held_fly", 32'(state), 32'd0);
      cycle(1'b0, 1'b0, 10'd0, 1'b0);
      cycle(1'b1, 1'b0, 10'd0, 1'b0);
      check("refly", 32'(state), 32'd1);

      repeat (4000) begin
         f = ($urandom_range(0, 3) == 0) ? ~fly : fly;
         c = (m_state == 1) ? ($urandom_range(0, 24) == 0) : 1'($urandom_range(0, 1));
         r = ($urandom_range(0, 299) == 0);
         s = 10'($urandom_range(0, 1023));
         cycle(f, c, s, r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter BIRD_TICK_DIV, default 2**20, clock cycles between bird_tick pulses (>=2).
REQ-002 Parameter OBSTACLE_TICK_DIV, default 2**21, clock cycles between obstacle_tick pulses (>=2).
REQ-003 Parameter HOLD_CYCLES, default 2**25, minimum OVER dwell in cycles before restart is accepted (>=1).
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 fly  input  1  flap request, level, already synchronized, active-high.
REQ-007 collision  input  1  collision flag from collision detector, level.
REQ-008 score_in  input  10  current score from score counter.
REQ-009 state  output  2  current game_state_t: IDLE=0, RUN=1, OVER=2.
REQ-010 world_reset  output  1  holds bird/obstacles/score at initial values.
REQ-011 bird_tick  output  1  one-cycle enable for bird update.
REQ-012 obstacle_tick  output  1  one-cycle enable for obstacle/score update.
REQ-013 game_over  output  1  high while in OVER.
REQ-014 high_score  output  10  best score since reset.
REQ-015 new_record  output  1  high while in OVER if the last game set a new high_score.

Function
REQ-016 fly_rise SHALL equal fly & ~fly_q, fly_q being fly registered each cycle; held fly never retriggers.
REQ-017 IDLE: world_reset=1, ticks=0, game_over=0; fly_rise -> RUN next cycle; collision ignored.
REQ-018 RUN: world_reset=0; both tick dividers cleared on entry, so first bird_tick occurs exactly BIRD_TICK_DIV cycles after state becomes RUN.
REQ-019 Each divider counts 0..DIV-1, asserts its tick for the one cycle count==DIV-1, then wraps to 0; counters are 32 bits.
REQ-020 RUN: collision=1 -> OVER next cycle; both tick outputs forced 0 in any cycle collision=1.
REQ-021 RUN: fly ignored for state transitions.
REQ-022 On RUN->OVER: if score_in > high_score, high_score <= score_in and new_record <= 1, else both unchanged/0; comparison unsigned 10-bit.
REQ-023 OVER: game_over=1, ticks=0, world_reset=0 (final picture frozen); hold counter loaded with HOLD_CYCLES-1 on entry, decrements to 0 and sticks.
REQ-024 OVER: fly_rise while hold counter != 0 ignored; fly_rise with counter == 0 -> IDLE next cycle.
REQ-025 Entering IDLE clears new_record; high_score retained.
REQ-026 All outputs are registered or decoded from registered state only; no combinational path from fly or collision to state/world_reset/game_over.

Reset
REQ-027 reset=1 at any clock edge, in any state or mid-count: state=IDLE, dividers=0, hold counter=0, fly_q=0, high_score=0, new_record=0, world_reset=1, ticks=0, game_over=0.
REQ-028 reset has priority over every simultaneous input.

Structure
REQ-029 game_state_t enum and default divider/hold constants SHALL live in package Constants.
REQ-030 One sub-module tick_divider (parameter DIV; ports clock, clear, tick) SHALL be instantiated twice.

Verification (BIRD_TICK_DIV=4, OBSTACLE_TICK_DIV=8, HOLD_CYCLES=10)
REQ-031 Reset, fly held 0 for 20 cycles -> state=IDLE, world_reset=1, no ticks, high_score=0.
REQ-032 fly 0->1 in IDLE -> state=RUN next cycle; bird_tick at cycles 4,8,12 after entry; obstacle_tick at 8,16.
REQ-033 In RUN, collision=1 on a cycle where bird_tick is due -> bird_tick=0 that cycle; state=OVER next cycle; game_over=1.
REQ-034 score_in=37 at collision with high_score=0 -> high_score=37, new_record=1; next game score_in=12 -> high_score=37, new_record=0.
REQ-035 In OVER, fly_rise 5 cycles after entry -> stays OVER; fly_rise 12 cycles after entry -> IDLE, world_reset=1, new_record=0.
REQ-036 reset asserted in RUN mid-count -> next cycle IDLE, high_score=0; fly held high through reset release causes no RUN until fly falls and rises again.
